// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for the 5-stage core. Merges the load-use hazard,
// EX branch-taken, data-memory busy and halt request into write-enable / flush
// controls for the PC and the pipeline registers, owns the multi-cycle states
// (memory wait, halt drain, timeout error) and keeps saturating event counters.
//
// Ports:
//   clk             core clock, rising edge
//   rst_n           asynchronous active-low reset
//   hazard_detected load-use hazard flag from the hazard unit
//   branch_taken    branch/jump resolved taken in EX this cycle
//   mem_busy        data memory has not completed its access this cycle
//   halt_req        halt/ecall decoded in ID
//   pc_write        PC load enable
//   if_id_write     IF/ID load enable
//   if_id_flush     IF/ID loaded with a NOP
//   id_ex_flush     ID/EX loaded with a bubble
//   back_write      shared load enable for ID/EX, EX/MEM, MEM/WB
//   halted          core halted, sticky until reset
//   timeout_err     memory timeout occurred, sticky until reset
//   stall_cnt       saturating count of stalled RUN/MEM_WAIT cycles
//   flush_cnt       saturating count of branch flushes

module pipeline_stall_ctrl #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned MEM_TIMEOUT  = 64,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_busy,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             back_write,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

   // Busy-cycle count held in the timeout counter when one more busy cycle hits the limit.
   localparam logic [TW-1:0] TMO_LAST  = TW'(MEM_TIMEOUT - 1);
   localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_CYCLES);

   typedef enum logic [2:0] {
      StRun,
      StMemWait,
      StDrain,
      StHalted,
      StErr
   } state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic             halted_q, timeout_err_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Ungated controls; the reset gate is applied on the way out.
   logic pc_write_int, if_id_write_int, if_id_flush_int, id_ex_flush_int, back_write_int;
   logic stall_inc, flush_inc;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         tmo_cnt_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         StRun: begin
            if (mem_busy) begin
               state_d   = StMemWait;
               tmo_cnt_d = TW'(1);
            end else if (branch_taken) begin
               // halt/hazard of a squashed instruction are dropped
               state_d = StRun;
            end else if (halt_req) begin
               state_d     = StDrain;
               drain_cnt_d = DW'(1);
            end
         end
         StMemWait: begin
            if (!mem_busy) begin
               state_d   = StRun;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
               if (tmo_cnt_q == TMO_LAST) begin
                  state_d = StErr;
               end
            end
         end
         StDrain: begin
            // A busy memory holds the drain so in-flight stores complete.
            if (!mem_busy) begin
               if (drain_cnt_q == DRAIN_END) begin
                  state_d = StHalted;
               end else begin
                  drain_cnt_d = drain_cnt_q + DW'(1);
               end
            end
         end
         StHalted: state_d = StHalted;
         StErr:    state_d = StErr;
         default:  state_d = StRun;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_write_int    = 1'b0;
      if_id_write_int = 1'b0;
      if_id_flush_int = 1'b0;
      id_ex_flush_int = 1'b0;
      back_write_int  = 1'b0;
      case (state_q)
         StRun: begin
            if (mem_busy) begin
               pc_write_int    = 1'b0;
            end else if (branch_taken) begin
               pc_write_int    = 1'b1;
               if_id_write_int = 1'b1;
               back_write_int  = 1'b1;
               if_id_flush_int = 1'b1;
               id_ex_flush_int = 1'b1;
            end else if (halt_req) begin
               if_id_write_int = 1'b1;
               back_write_int  = 1'b1;
               if_id_flush_int = 1'b1;
            end else if (hazard_detected) begin
               back_write_int  = 1'b1;
               id_ex_flush_int = 1'b1;
            end else begin
               pc_write_int    = 1'b1;
               if_id_write_int = 1'b1;
               back_write_int  = 1'b1;
            end
         end
         StMemWait: begin
            // Release in the same cycle memory completes.
            if (!mem_busy) begin
               pc_write_int    = 1'b1;
               if_id_write_int = 1'b1;
               back_write_int  = 1'b1;
            end
         end
         StDrain: begin
            // Keep injecting NOPs into IF/ID while older instructions retire.
            if_id_write_int = 1'b1;
            if_id_flush_int = 1'b1;
            back_write_int  = !mem_busy;
         end
         default: begin
            pc_write_int = 1'b0;
         end
      endcase
   end

   assign pc_write    = pc_write_int & rst_n;
   assign if_id_write = if_id_write_int & rst_n;
   assign if_id_flush = if_id_flush_int & rst_n;
   assign id_ex_flush = id_ex_flush_int & rst_n;
   assign back_write  = back_write_int & rst_n;

   // ---------------------------------------------------------------------------
   // Sticky status and performance counters
   // ---------------------------------------------------------------------------
   assign stall_inc = !pc_write_int && ((state_q == StRun) || (state_q == StMemWait));
   assign flush_inc = (state_q == StRun) && !mem_busy && branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         halted_q      <= halted_q | (state_d == StHalted);
         timeout_err_q <= timeout_err_q | (state_d == StErr);
         if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign halted      = halted_q;
   assign timeout_err = timeout_err_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Instance u_a uses the default memory
// timeout; instance u_b shares its inputs and uses MEM_TIMEOUT=4 for the timeout cases.
// Control outputs are compared as {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write}.

module tb_pipeline_stall_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic hazard_detected, branch_taken, mem_busy, halt_req;

   logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_back_write;
   logic        a_halted, a_timeout_err;
   logic [15:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_back_write;
   logic        b_halted, b_timeout_err;
   logic [15:0] b_stall_cnt, b_flush_cnt;

   logic [4:0] a_ctrl, b_ctrl;
   assign a_ctrl = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_back_write};
   assign b_ctrl = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_back_write};

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64), .DRAIN_CYCLES(3)) u_a (
      .clk(clk), .rst_n(rst_n),
      .hazard_detected(hazard_detected), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .halt_req(halt_req),
      .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
      .id_ex_flush(a_id_ex_flush), .back_write(a_back_write),
      .halted(a_halted), .timeout_err(a_timeout_err),
      .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   pipeline_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4), .DRAIN_CYCLES(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .hazard_detected(hazard_detected), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .halt_req(halt_req),
      .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
      .id_ex_flush(b_id_ex_flush), .back_write(b_back_write),
      .halted(b_halted), .timeout_err(b_timeout_err),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge.
   task automatic drive(input logic hz, input logic br, input logic mb, input logic hr);
      @(negedge clk);
      hazard_detected = hz;
      branch_taken    = br;
      mem_busy        = mb;
      halt_req        = hr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      hazard_detected = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        hz;
      logic        br;
      logic        hr;
      logic [4:0]  ctrl;
      int unsigned stall;
      int unsigned flush;
   } vec_t;

   vec_t vecs [8];

   initial begin
      // RUN-state vectors applied back to back from reset; counts are cumulative.
      vecs[0] = '{1'b1, 1'b1, 1'b0, 5'b11111, 0, 1};  // branch wins over hazard
      vecs[1] = '{1'b1, 1'b0, 1'b0, 5'b00011, 1, 1};  // load-use bubble
      vecs[2] = '{1'b0, 1'b0, 1'b0, 5'b11001, 1, 1};  // back to defaults
      vecs[3] = '{1'b0, 1'b1, 1'b1, 5'b11111, 1, 2};  // branch squashes halt
      vecs[4] = '{1'b1, 1'b0, 1'b0, 5'b00011, 2, 2};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 5'b00011, 3, 2};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 5'b11111, 3, 3};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 5'b11001, 3, 3};

      rst_n = 1'b0;
      hazard_detected = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
      #12;
      // Reset state
      check("rst_ctrl", 32'(a_ctrl), 32'h0);
      check("rst_stall", 32'(a_stall_cnt), 32'd0);
      check("rst_flush", 32'(a_flush_cnt), 32'd0);
      check("rst_halted", 32'(a_halted), 32'd0);
      check("rst_tmo", 32'(a_timeout_err), 32'd0);
      do_reset();

      // Table-driven RUN vectors
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].hz, vecs[i].br, 1'b0, vecs[i].hr);
         check($sformatf("vec%0d_ctrl", i), 32'(a_ctrl), 32'(vecs[i].ctrl));
         tick();
         check($sformatf("vec%0d_stall", i), 32'(a_stall_cnt), 32'(vecs[i].stall));
         check($sformatf("vec%0d_flush", i), 32'(a_flush_cnt), 32'(vecs[i].flush));
      end

      // Memory wait: 5 busy cycles, released in cycle 6 (u_b times out meanwhile)
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, (i == 2), 1'b1, 1'b0);
         check($sformatf("mw_busy%0d_ctrl", i), 32'(a_ctrl), 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("mw_release_ctrl", 32'(a_ctrl), 32'b11001);
      check("mw_b_err_ctrl", 32'(b_ctrl), 32'h0);
      tick();
      check("mw_stall", 32'(a_stall_cnt), 32'd5);
      check("mw_flush", 32'(a_flush_cnt), 32'd0);
      check("mw_tmo", 32'(a_timeout_err), 32'd0);
      check("mw_b_tmo", 32'(b_timeout_err), 32'd1);

      // One short of the timeout: 3 busy cycles on u_b, then release
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("to3_release_ctrl", 32'(b_ctrl), 32'b11001);
      tick();
      check("to3_tmo", 32'(b_timeout_err), 32'd0);

      // Timeout: busy held, ERR after the 4th busy cycle
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0);
         tick();
      end
      check("to_pre_tmo", 32'(b_timeout_err), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("to_tmo", 32'(b_timeout_err), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         check($sformatf("to_err%0d_ctrl", i), 32'(b_ctrl), 32'h0);
         tick();
      end
      check("to_err_flush", 32'(b_flush_cnt), 32'd0);
      check("to_err_sticky", 32'(b_timeout_err), 32'd1);

      // Halt with one busy cycle during drain
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("halt_req_ctrl", 32'(a_ctrl), 32'b01101);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);  // branch ignored in drain
      check("drain1_ctrl", 32'(a_ctrl), 32'b01101);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check("drain2_ctrl", 32'(a_ctrl), 32'b01100);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("drain3_ctrl", 32'(a_ctrl), 32'b01101);
      tick();
      check("drain3_halted", 32'(a_halted), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("drain4_ctrl", 32'(a_ctrl), 32'b01101);
      tick();
      check("halted", 32'(a_halted), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1);
         check($sformatf("halted%0d_ctrl", i), 32'(a_ctrl), 32'h0);
         tick();
      end
      check("halted_sticky", 32'(a_halted), 32'd1);
      check("halt_stall", 32'(a_stall_cnt), 32'd1);
      check("halt_flush", 32'(a_flush_cnt), 32'd0);

      // Async reset in the middle of MEM_WAIT
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("ar_pre_stall", 32'(a_stall_cnt), 32'd3);
      check("ar_pre_flush", 32'(a_flush_cnt), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("ar_release_ctrl", 32'(a_ctrl), 32'b11001);
      rst_n = 1'b0;
      #1;
      check("ar_ctrl", 32'(a_ctrl), 32'h0);
      check("ar_stall", 32'(a_stall_cnt), 32'd0);
      check("ar_flush", 32'(a_flush_cnt), 32'd0);
      tick();
      check("ar_hold_ctrl", 32'(a_ctrl), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ar_run_ctrl", 32'(a_ctrl), 32'b11001);
      tick();
      check("ar_run_stall", 32'(a_stall_cnt), 32'd0);
      check("ar_run_flush", 32'(a_flush_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
